instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 35 +++
 rtl/instr_fetch.sv | 94 +++++++++
 tb/tb_instr_fetch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch unit bus bundle: instruction memory side and downstream side
//
// Purpose: groups every handshake/bus signal of instr_fetch.
// Ports (signals):
//   imem_req, imem_addr[31:0]   fetch -> memory  read request / word address
//   imem_ack, imem_rdata[31:0]  memory -> fetch  data return
//   instr_valid, instr[31:0], op[5:0], funct[5:0], pc[31:0]
//                               fetch -> decode  held instruction
//   instr_ready, jump, branch_taken
//                               decode -> fetch  consume / redirect
// Modports: master = fetch unit, slave = memory + decode environment.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic        jump;
  logic        branch_taken;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, funct, pc,
    input  imem_ack, imem_rdata, instr_ready, jump, branch_taken
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, funct, pc,
    output imem_ack, imem_rdata, instr_ready, jump, branch_taken
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with jump/branch redirect
//
// Purpose: fetches one word at PC, holds it for decode until consumed, then
// moves PC to the sequential, branch or jump target.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   bus            instr_fetch_if.master (memory request/return, held instruction,
//                  instr_ready, jump, branch_taken)
//   retired_count  out  32-bit retire counter, present only with IFETCH_PERF_EN
// Parameters: RESET_PC - PC loaded on reset.
// Optional feature macro: IFETCH_PERF_EN (adds retired_count).
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_if.master       bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         retired_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        retire;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign retire = (state == HOLD) && bus.instr_ready;
  assign pc4    = pc_q + 32'd4;
  // Word offset: sign-extended imm16 scaled by 4; adds wrap modulo 2^32.
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump has priority over branch when both are raised.
  always_comb begin
    next_pc = pc4;
    if (bus.jump)
      next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
    else if (bus.branch_taken)
      next_pc = pc4 + br_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (retire) begin
            pc_q  <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      retired_count <= '0;
    else if (retire)
      retired_count <= retired_count + 32'd1;
  end
`endif

  // Request and valid decode from disjoint states, so they never overlap.
  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state == HOLD);
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;
  int   req_cyc;
  int   req_cyc_prev;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t sb_q[$];

  instr_fetch_if bus ();

`ifdef IFETCH_PERF_EN
  logic [31:0] retired_count;
  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus), .retired_count(retired_count)
  );
`else
  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word,
                           input int ack_dly, input int rdy_dly,
                           input logic j, input logic b, input logic rst_on_retire);
    int   t;
    exp_t e;
    t = 0;
    while (!bus.imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.imem_req) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    req_cyc_prev = req_cyc;
    req_cyc      = cyc;
    check("addr", bus.imem_addr, exp_addr);
    check("valid_in_fetch", {31'd0, bus.instr_valid}, 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      check("addr_hold", bus.imem_addr, exp_addr);
      check("req_hold", {31'd0, bus.imem_req}, 32'd1);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    sb_q.push_back('{exp_addr, word});
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    t = 0;
    while (!bus.instr_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.instr_valid) begin
      check("valid_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("instr", bus.instr, e.word);
    check("op", {26'd0, bus.op}, {26'd0, e.word[31:26]});
    check("funct", {26'd0, bus.funct}, {26'd0, e.word[5:0]});
    check("pc", bus.pc, e.pc);
    check("req_in_hold", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      // Stray ack, data and redirects while stalled must not disturb anything.
      bus.imem_ack     = 1'b1;
      bus.imem_rdata   = ~word;
      bus.jump         = 1'b1;
      bus.branch_taken = 1'b1;
      @(negedge clk);
      check("instr_hold", bus.instr, e.word);
      check("funct_hold", {26'd0, bus.funct}, {26'd0, e.word[5:0]});
      check("pc_hold", bus.pc, e.pc);
      check("valid_hold", {31'd0, bus.instr_valid}, 32'd1);
    end
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 32'hDEAD_BEEF;
    bus.instr_ready  = 1'b1;
    bus.jump         = j;
    bus.branch_taken = b;
    if (rst_on_retire) rst = 1'b1;
    @(negedge clk);
    rst              = 1'b0;
    bus.instr_ready  = 1'b0;
    bus.jump         = 1'b0;
    bus.branch_taken = 1'b0;
    check("valid_drop", {31'd0, bus.instr_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    cyc = 0;
    req_cyc = 0;
    req_cyc_prev = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    bus.jump = 1'b0;
    bus.branch_taken = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_pc", bus.pc, 32'd0);
`ifdef IFETCH_PERF_EN
    check("rst_count", retired_count, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("first_req", {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'd0);

    // Back-to-back sequential fetches at full rate.
    fetch_one(32'h0, 32'h0000_0020, 0, 0, 0, 0, 0);
    fetch_one(32'h4, 32'h0000_0021, 0, 0, 0, 0, 0);
    check("throughput", req_cyc - req_cyc_prev, 32'd2);
    fetch_one(32'h8, 32'h0000_0022, 0, 0, 0, 0, 0);
    check("throughput", req_cyc - req_cyc_prev, 32'd2);
    fetch_one(32'hC, 32'h0000_0023, 0, 0, 0, 0, 0);
    check("throughput", req_cyc - req_cyc_prev, 32'd2);
`ifdef IFETCH_PERF_EN
    check("count4", retired_count, 32'd4);
`endif
    // Negative branch wrapping below zero, then sequential wrap past the top.
    fetch_one(32'h10, 32'h1000_FFFA, 0, 0, 0, 1, 0);
    fetch_one(32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 0, 0, 0);
    fetch_one(32'h0, 32'h0800_0010, 0, 0, 1, 0, 0);
    // Positive and negative branch from 0x40.
    fetch_one(32'h40, 32'h1000_0003, 0, 0, 0, 1, 0);
    fetch_one(32'h50, 32'h0800_0010, 0, 0, 1, 0, 0);
    fetch_one(32'h40, 32'h1000_FFFF, 0, 0, 0, 1, 0);
    // Stalled ack and stalled ready, ending in a jump.
    fetch_one(32'h40, 32'h0BFF_FFFF, 3, 2, 1, 0, 0);
    fetch_one(32'h0FFF_FFFC, 32'h0800_0000, 0, 0, 1, 0, 0);
    // Jump and branch together resolve as jump.
    fetch_one(32'h1000_0000, 32'h0800_0010, 1, 1, 1, 1, 0);

    // Reset during FETCH with a coincident ack.
    check("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
    check("pre_rst_addr", bus.imem_addr, 32'h1000_0040);
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    check("rstf_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rstf_instr", bus.instr, 32'd0);
`ifdef IFETCH_PERF_EN
    check("rstf_count", retired_count, 32'd0);
`endif
    @(negedge clk);
    check("rstf_valid2", {31'd0, bus.instr_valid}, 32'd0);
    check("rstf_req", {31'd0, bus.imem_req}, 32'd1);
    check("rstf_addr", bus.imem_addr, 32'd0);

    // Reset coinciding with a would-be retire: no redirect, no retire.
    fetch_one(32'h0, 32'h0800_0100, 0, 0, 1, 0, 1);
    check("rsth_instr", bus.instr, 32'd0);
    @(negedge clk);
    check("rsth_addr", bus.imem_addr, 32'd0);
`ifdef IFETCH_PERF_EN
    check("rsth_count", retired_count, 32'd0);
`endif
    fetch_one(32'h0, 32'h0000_0020, 0, 0, 0, 0, 0);
    fetch_one(32'h4, 32'h0000_0020, 0, 0, 0, 0, 0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
